// File: rtl/sp_mem_arbiter.sv
// sp_mem_arbiter
// Serialises the per-lane requests of a warp onto one single-port synchronous
// memory, one lane per cycle, lowest enabled lane first. Read data is written
// back into the issuing lane's q slot; MReady pulses once per warp access.
//
// Ports
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   MRead, MWrite   : warp request levels (write wins when both are high)
//   en              : lane enable mask, sampled at the start of an access
//   addr, data      : packed per-lane address / write data, lane i at [i*W +: W]
//   q               : packed per-lane read data (registered)
//   MReady          : one-cycle completion pulse
//   mem_addr, mem_wdata, mem_we, mem_re : memory request (registered)
//   mem_rdata       : memory read data, valid the cycle after mem_re
module sp_mem_arbiter #(
  parameter int N_CORES = 8,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MRead,
  input  logic                  MWrite,
  input  logic [N_CORES-1:0]    en,
  input  logic [N_CORES*AW-1:0] addr,
  input  logic [N_CORES*DW-1:0] data,
  output logic [N_CORES*DW-1:0] q,
  output logic                  MReady,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DW-1:0]         mem_rdata
);

  localparam int LW = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [N_CORES-1:0]   pend_q, pend_d;
  logic                 armed_q, armed_d;
  logic                 op_wr_q, op_wr_d;
  logic [LW-1:0]        lane_q, lane_d;      // lane driven on the memory port
  logic                 rd_vld_q;            // a read was issued last cycle
  logic [LW-1:0]        rd_lane_q;           // ...for this lane
  logic                 mready_q, mready_d;
  logic [AW-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]        mem_wdata_q, mem_wdata_d;
  logic                 mem_we_q, mem_we_d;
  logic                 mem_re_q, mem_re_d;
  logic                 start;
  logic                 snap_load;

  logic [AW-1:0]        addr_lane [N_CORES];
  logic [DW-1:0]        data_lane [N_CORES];
  logic [AW-1:0]        snap_addr_q [N_CORES];
  logic [DW-1:0]        snap_data_q [N_CORES];
  logic [DW-1:0]        q_q [N_CORES];

  for (genvar gi = 0; gi < N_CORES; gi++) begin : g_lane
    assign addr_lane[gi]       = addr[gi*AW +: AW];
    assign data_lane[gi]       = data[gi*DW +: DW];
    assign q[gi*DW +: DW]      = q_q[gi];
  end

  assign MReady    = mready_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

  // Index of the lowest set bit (0 when the mask is empty).
  function automatic logic [LW-1:0] lowest(input logic [N_CORES-1:0] m);
    lowest = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (m[i]) lowest = LW'(i);
    end
  endfunction

  // Memory-port outputs are computed one cycle ahead so that they come
  // straight from flops during the ISSUE cycle they belong to.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    op_wr_d     = op_wr_q;
    lane_d      = lane_q;
    mready_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    start       = 1'b0;
    snap_load   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (armed_q && (MRead || MWrite)) begin
          start     = 1'b1;
          snap_load = 1'b1;
          op_wr_d   = MWrite;
          pend_d    = en;
          if (en == '0) begin
            state_d  = S_DONE;
            mready_d = 1'b1;
          end else begin
            // Snapshot is loading at this same edge, so use the live inputs.
            state_d     = S_ISSUE;
            lane_d      = lowest(en);
            mem_addr_d  = addr_lane[lane_d];
            mem_wdata_d = data_lane[lane_d];
            mem_we_d    = MWrite;
            mem_re_d    = !MWrite;
          end
        end
      end
      S_ISSUE: begin
        pend_d[lane_q] = 1'b0;
        if (pend_d != '0) begin
          lane_d      = lowest(pend_d);
          mem_addr_d  = snap_addr_q[lane_d];
          mem_wdata_d = snap_data_q[lane_d];
          mem_we_d    = op_wr_q;
          mem_re_d    = !op_wr_q;
        end else if (op_wr_q) begin
          state_d  = S_DONE;
          mready_d = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d  = S_DONE;
        mready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A request level must be seen low before another access may start.
    armed_d = armed_q;
    if (!(MRead || MWrite)) armed_d = 1'b1;
    else if (start)         armed_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      armed_q     <= 1'b1;
      op_wr_q     <= 1'b0;
      lane_q      <= '0;
      rd_vld_q    <= 1'b0;
      rd_lane_q   <= '0;
      mready_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      for (int i = 0; i < N_CORES; i++) begin
        snap_addr_q[i] <= '0;
        snap_data_q[i] <= '0;
        q_q[i]         <= '0;
      end
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      armed_q     <= armed_d;
      op_wr_q     <= op_wr_d;
      lane_q      <= lane_d;
      mready_q    <= mready_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      // Read capture runs one cycle behind issue, overlapping the next issue.
      rd_vld_q    <= mem_re_q;
      rd_lane_q   <= lane_q;
      if (rd_vld_q) q_q[rd_lane_q] <= mem_rdata;
      if (snap_load) begin
        for (int i = 0; i < N_CORES; i++) begin
          snap_addr_q[i] <= addr_lane[i];
          snap_data_q[i] <= data_lane[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_sp_mem_arbiter.sv
module tb_sp_mem_arbiter;
  localparam int N  = 8;
  localparam int AW = 16;
  localparam int DW = 16;

  logic              clk;
  logic              reset;
  logic              MRead, MWrite;
  logic [N-1:0]      en;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   data;
  logic [N*DW-1:0]   q;
  logic              MReady;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_we, mem_re;
  logic [DW-1:0]     mem_rdata = '0;

  sp_mem_arbiter #(.N_CORES(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .MRead(MRead), .MWrite(MWrite), .en(en),
    .addr(addr), .data(data), .q(q), .MReady(MReady), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical memory behind the DUT: unwritten locations read as addr^5555.
  bit [15:0] phys [bit [15:0]];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= phys.exists(mem_addr) ? phys[mem_addr] : (mem_addr ^ 16'h5555);
    if (mem_we) phys[mem_addr] = mem_wdata;
  end

  // ---------------- reference model ----------------
  // Each access becomes a list of per-cycle expectations: one memory beat per
  // enabled lane in ascending order, a drain beat for reads, then MReady.
  typedef struct {
    bit        we;
    bit        re;
    bit        rdy;
    bit [15:0] a;
    bit [15:0] d;
  } exp_t;

  exp_t      sched[$];
  bit [15:0] mmem [bit [15:0]];
  bit [15:0] q_exp [N];
  bit [15:0] q_aft [N];
  bit        armed_m = 1'b1;

  function automatic bit [15:0] mval(input bit [15:0] a);
    return mmem.exists(a) ? mmem[a] : (a ^ 16'h5555);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sched.delete();
      armed_m = 1'b1;
      for (int i = 0; i < N; i++) begin
        q_exp[i] = '0;
        q_aft[i] = '0;
      end
    end else begin
      bit idle, req, st;
      exp_t e;
      idle = (sched.size() == 0);
      if (!idle) begin
        if (sched[0].rdy) q_exp = q_aft;
        void'(sched.pop_front());
      end
      req = MRead | MWrite;
      st  = idle && armed_m && req;
      if (st) begin
        q_aft = q_exp;
        for (int j = 0; j < N; j++) begin
          if (en[j]) begin
            e.we  = MWrite;
            e.re  = !MWrite;
            e.rdy = 1'b0;
            e.a   = addr[j*AW +: AW];
            e.d   = data[j*DW +: DW];
            sched.push_back(e);
            if (MWrite) mmem[e.a] = e.d;
            else        q_aft[j] = mval(e.a);
          end
        end
        e = '{we: 1'b0, re: 1'b0, rdy: 1'b0, a: 16'h0, d: 16'h0};
        if (!MWrite && en != '0) sched.push_back(e);
        e.rdy = 1'b1;
        sched.push_back(e);
      end
      if (!req)    armed_m = 1'b1;
      else if (st) armed_m = 1'b0;
    end
  end

  // ---------------- checking ----------------
  int        checks = 0;
  int        errors = 0;
  int        we_cnt = 0, re_cnt = 0, rdy_cnt = 0;
  bit [15:0] addr_log[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // One cycle: wait for the falling edge and compare every output to the model.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      if (sched.size() > 0) e = sched[0];
      else e = '{we: 1'b0, re: 1'b0, rdy: 1'b0, a: 16'h0, d: 16'h0};
      chk("MReady", {31'd0, MReady}, {31'd0, e.rdy});
      chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
      chk("mem_re", {31'd0, mem_re}, {31'd0, e.re});
      if (e.we || e.re) chk("mem_addr", {16'd0, mem_addr}, {16'd0, e.a});
      if (e.we)         chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.d});
      for (int i = 0; i < N; i++) begin
        if (sched.size() == 0) chk($sformatf("q%0d_idle", i), {16'd0, q[i*DW +: DW]}, {16'd0, q_exp[i]});
        else if (e.rdy)        chk($sformatf("q%0d_rdy", i), {16'd0, q[i*DW +: DW]}, {16'd0, q_aft[i]});
      end
      if (mem_we) we_cnt++;
      if (mem_re) re_cnt++;
      if (MReady) rdy_cnt++;
      if (mem_we || mem_re) addr_log.push_back(mem_addr);
    end
  endtask

  task automatic set_lanes(input logic [15:0] ab, input logic [15:0] db);
    for (int i = 0; i < N; i++) begin
      addr[i*AW +: AW] = ab + 16'(i);
      data[i*DW +: DW] = db + 16'(i);
    end
  endtask

  // Raise the request, hold it for 'hold' cycles, run until MReady; lat is
  // the cycle (counted after the start edge) in which MReady was seen.
  task automatic do_op(input logic rd, input logic wr, input logic [7:0] m,
                       input int hold, input bit scramble, output int lat);
    bit seen;
    MRead = rd; MWrite = wr; en = m;
    lat = 0; seen = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (MReady && !seen) begin
        seen = 1'b1;
        lat  = n;
      end
      if (n == hold) begin
        MRead = 1'b0; MWrite = 1'b0;
      end
      if (scramble) begin
        en = 8'($urandom);
        for (int i = 0; i < N; i++) begin
          addr[i*AW +: AW] = 16'($urandom);
          data[i*DW +: DW] = 16'($urandom);
        end
      end
      if (seen && n >= hold) break;
    end
    chk("op_done", {31'd0, seen}, 32'd1);
    MRead = 1'b0; MWrite = 1'b0;
    tick();
  endtask

  initial begin
    int lat, b_we, b_re, b_rdy, b_log, op, hold;
    logic [7:0] m;
    reset = 1'b1; MRead = 1'b0; MWrite = 1'b0; en = '0;
    set_lanes(16'h0, 16'h0);

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_MReady", {31'd0, MReady}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_re", {31'd0, mem_re}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_q_lo", q[31:0], 32'd0);
    reset = 1'b0;
    tick();

    // Full write
    set_lanes(16'h0100, 16'hA000);
    b_we = we_cnt; b_log = addr_log.size();
    do_op(1'b0, 1'b1, 8'hFF, 1, 1'b0, lat);
    chk("wr_lat", lat, 32'd9);
    chk("wr_cnt", we_cnt - b_we, 32'd8);
    chk("wr_first_addr", {16'd0, addr_log[b_log]}, 32'h0100);
    chk("wr_last_addr", {16'd0, addr_log[b_log+7]}, 32'h0107);

    // Sparse read
    set_lanes(16'h0200, 16'h0000);
    b_re = re_cnt; b_log = addr_log.size();
    do_op(1'b1, 1'b0, 8'b10100101, 1, 1'b0, lat);
    chk("rd_lat", lat, 32'd6);
    chk("rd_cnt", re_cnt - b_re, 32'd4);
    chk("rd_third_addr", {16'd0, addr_log[b_log+2]}, 32'h0205);
    chk("rd_q0", {16'd0, q[0*DW +: DW]}, 32'h5755);
    chk("rd_q2", {16'd0, q[2*DW +: DW]}, 32'h5757);
    chk("rd_q5", {16'd0, q[5*DW +: DW]}, 32'h5750);
    chk("rd_q7", {16'd0, q[7*DW +: DW]}, 32'h5752);
    chk("rd_q1", {16'd0, q[1*DW +: DW]}, 32'h0000);
    chk("rd_q6", {16'd0, q[6*DW +: DW]}, 32'h0000);

    // Asynchronous reset with q preloaded
    @(posedge clk); #3 reset = 1'b1;
    #1 chk("arst_q", {16'd0, q[5*DW +: DW]}, 32'd0);
    chk("arst_MReady", {31'd0, MReady}, 32'd0);
    @(negedge clk); reset = 1'b0;
    tick();

    // Empty mask
    b_we = we_cnt; b_re = re_cnt;
    do_op(1'b1, 1'b0, 8'h00, 1, 1'b0, lat);
    chk("empty_lat", lat, 32'd1);
    chk("empty_strobes", (we_cnt - b_we) + (re_cnt - b_re), 32'd0);

    // Held request: one access only, then a re-raise gives another
    set_lanes(16'h0100, 16'h0000);
    b_rdy = rdy_cnt;
    do_op(1'b1, 1'b0, 8'h03, 20, 1'b0, lat);
    chk("held_lat", lat, 32'd4);
    chk("held_once", rdy_cnt - b_rdy, 32'd1);
    do_op(1'b1, 1'b0, 8'h03, 1, 1'b0, lat);
    chk("rearm_twice", rdy_cnt - b_rdy, 32'd2);

    // Read and write together: write only
    set_lanes(16'h0300, 16'hC000);
    b_we = we_cnt; b_re = re_cnt;
    do_op(1'b1, 1'b1, 8'h0F, 1, 1'b0, lat);
    chk("conf_lat", lat, 32'd5);
    chk("conf_we", we_cnt - b_we, 32'd4);
    chk("conf_re", re_cnt - b_re, 32'd0);

    // Abort an 8-lane read in cycle 3
    set_lanes(16'h0100, 16'h0000);
    MRead = 1'b1; en = 8'hFF;
    tick();
    MRead = 1'b0;
    tick();
    @(posedge clk); #3 reset = 1'b1;
    #1 chk("abort_q", q[31:0], 32'd0);
    chk("abort_re", {31'd0, mem_re}, 32'd0);
    @(negedge clk); reset = 1'b0;
    b_rdy = rdy_cnt;
    repeat (12) tick();
    chk("abort_no_rdy", rdy_cnt - b_rdy, 32'd0);
    do_op(1'b1, 1'b0, 8'hFF, 1, 1'b0, lat);
    chk("after_abort_lat", lat, 32'd10);
    chk("after_abort_q3", {16'd0, q[3*DW +: DW]}, 32'hA003);

    // Randomised accesses with snapshot disturbance and long holds
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 2);
      m  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      for (int i = 0; i < N; i++) begin
        addr[i*AW +: AW] = 16'h0300 + 16'($urandom_range(0, 15));
        data[i*DW +: DW] = 16'($urandom);
      end
      hold = $urandom_range(1, 14);
      do_op(op != 1, op != 0, m, hold, 1'($urandom_range(0, 1)), lat);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
